// File: rtl/lp805x_sfr_arbiter.sv
// ---------------------------------------------------------------------------
// lp805x_sfr_arbiter : round-robin sharing of one SFR peripheral port. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lp805x_sfr_arbiter #(
  parameter int NREQ    = 2,
  parameter int BUS_W   = 29,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_rd,
  input  logic [NREQ*BUS_W-1:0] req_bus,
  output logic [NREQ-1:0]       req_ack,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [7:0]            rsp_data,
  output logic                  rsp_bit,
  output logic                  rsp_err,
  output logic [BUS_W-1:0]      sfr_bus,
  output logic                  sfr_put,
  input  logic                  sfr_wrdy,
  output logic                  sfr_get,
  input  logic                  sfr_rrdy,
  input  logic [7:0]            data_in,
  input  logic                  bit_in,
  output logic                  busy
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, gnt, pick;
  logic             pick_vld;
  logic [BUS_W-1:0] bus_q;
  logic             rd_q;
  logic             ack_pend;
  logic [TO_W-1:0]  cnt;
  logic             grant_en;
  logic             cap_en;
  logic [7:0]       cap_data;
  logic             cap_bit;
  logic             cap_err;

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    int idx;
    logic [IDX_W-1:0] sel;
    idx      = 0;
    sel      = '0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = IDX_W'(idx);
      if (!pick_vld && req_valid[sel]) begin
        pick_vld = 1'b1;
        pick     = sel;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_ack   = '0;
    rsp_valid = '0;
    sfr_bus   = '0;
    sfr_put   = 1'b0;
    sfr_get   = 1'b0;
    grant_en  = 1'b0;
    cap_en    = 1'b0;
    cap_data  = 8'h00;
    cap_bit   = 1'b0;
    cap_err   = 1'b0;
    case (state)
      IDLE: begin
        // A stale response left over from a timed-out read is flushed first.
        if (sfr_rrdy) begin
          sfr_get = 1'b1;
        end else if (pick_vld) begin
          grant_en  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        sfr_bus      = bus_q;
        req_ack[gnt] = ack_pend;
        sfr_put      = sfr_wrdy;
        if (sfr_wrdy) state_nxt = rd_q ? WAIT : IDLE;
      end
      WAIT: begin
        sfr_bus = bus_q;
        if (sfr_rrdy) begin
          sfr_get   = 1'b1;
          cap_en    = 1'b1;
          cap_data  = data_in;
          cap_bit   = bit_in;
          state_nxt = RESP;
        end else if (cnt == TO_LAST) begin
          cap_en    = 1'b1;
          cap_err   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid[gnt] = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= IDX_W'(NREQ - 1);
      gnt      <= '0;
      bus_q    <= '0;
      rd_q     <= 1'b0;
      ack_pend <= 1'b0;
      cnt      <= '0;
      rsp_data <= 8'h00;
      rsp_bit  <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_en) begin
        gnt      <= pick;
        rr_ptr   <= pick;
        bus_q    <= req_bus[int'(pick)*BUS_W +: BUS_W];
        rd_q     <= req_rd[pick];
        ack_pend <= 1'b1;
      end else if (state == ISSUE) begin
        ack_pend <= 1'b0;
      end
      if (state == ISSUE) begin
        cnt <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt + 1'b1;
      end
      if (cap_en) begin
        rsp_data <= cap_data;
        rsp_bit  <= cap_bit;
        rsp_err  <= cap_err;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_lp805x_sfr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lp805x_sfr_arbiter : directed bench for the SFR arbiter. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lp805x_sfr_arbiter;

  localparam int NREQ  = 2;
  localparam int BUS_W = 29;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_rd;
  logic [NREQ*BUS_W-1:0] req_bus;
  logic [NREQ-1:0]       req_ack;
  logic [NREQ-1:0]       rsp_valid;
  logic [7:0]            rsp_data;
  logic                  rsp_bit;
  logic                  rsp_err;
  logic [BUS_W-1:0]      sfr_bus;
  logic                  sfr_put;
  logic                  sfr_wrdy;
  logic                  sfr_get;
  logic                  sfr_rrdy;
  logic [7:0]            data_in;
  logic                  bit_in;
  logic                  busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lp805x_sfr_arbiter #(.NREQ(NREQ), .BUS_W(BUS_W), .TIMEOUT(64), .TO_W(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_rd    (req_rd),
    .req_bus   (req_bus),
    .req_ack   (req_ack),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_bit   (rsp_bit),
    .rsp_err   (rsp_err),
    .sfr_bus   (sfr_bus),
    .sfr_put   (sfr_put),
    .sfr_wrdy  (sfr_wrdy),
    .sfr_get   (sfr_get),
    .sfr_rrdy  (sfr_rrdy),
    .data_in   (data_in),
    .bit_in    (bit_in),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change 2 time units after the edge; outputs are checked 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_rd    = '0;
    req_bus   = '0;
    sfr_wrdy  = 1'b0;
    sfr_rrdy  = 1'b0;
    data_in   = 8'h00;
    bit_in    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [BUS_W-1:0] exp_bus;

    do_reset();
    settle();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", 32'(req_ack), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_put_get", {30'd0, sfr_put, sfr_get}, 32'd0);
    check("rst_bus", 32'(sfr_bus), 32'd0);
    check("rst_rsp", {23'd0, rsp_err, rsp_bit, rsp_data}, 32'd0);

    // Single write from requester 0
    req_valid = 2'b01;
    req_rd    = 2'b00;
    req_bus[0 +: BUS_W] = 29'h0ABCDEF;
    sfr_wrdy  = 1'b1;
    settle();
    check("wr_idle_ack", 32'(req_ack), 32'd0);
    tick();
    settle();
    check("wr_ack", 32'(req_ack), 32'b01);
    check("wr_put", 32'(sfr_put), 32'd1);
    check("wr_bus", 32'(sfr_bus), 32'h0ABCDEF);
    check("wr_busy", 32'(busy), 32'd1);
    req_valid = 2'b00;
    tick();
    settle();
    check("wr_done_busy", 32'(busy), 32'd0);
    check("wr_done_put", 32'(sfr_put), 32'd0);

    // Round robin right after reset: 0,1,0,1 every 2 cycles
    do_reset();
    sfr_wrdy  = 1'b1;
    req_valid = 2'b11;
    req_bus[0 +: BUS_W]     = 29'h1111111;
    req_bus[BUS_W +: BUS_W] = 29'h0222222;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("rr_idle_ack", 32'(req_ack), 32'd0);
      tick();
      settle();
      check("rr_ack", 32'(req_ack), (i % 2 == 0) ? 32'b01 : 32'b10);
      check("rr_bus", 32'(sfr_bus), (i % 2 == 0) ? 32'h1111111 : 32'h0222222);
      if (i == 3) req_valid = 2'b00;
      tick();
    end

    // Read from requester 1, response 5 cycles after the put
    req_valid = 2'b10;
    req_rd    = 2'b10;
    req_bus[BUS_W +: BUS_W] = 29'h1234567;
    tick();
    settle();
    check("rd_ack", 32'(req_ack), 32'b10);
    check("rd_put", 32'(sfr_put), 32'd1);
    req_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick();
      settle();
      check("rd_wait", {30'd0, sfr_get, |rsp_valid}, 32'd0);
    end
    tick();
    sfr_rrdy = 1'b1;
    data_in  = 8'hA5;
    bit_in   = 1'b1;
    settle();
    check("rd_get", 32'(sfr_get), 32'd1);
    check("rd_bus_held", 32'(sfr_bus), 32'h1234567);
    tick();
    sfr_rrdy = 1'b0;
    data_in  = 8'h00;
    bit_in   = 1'b0;
    settle();
    check("rd_rsp_valid", 32'(rsp_valid), 32'b10);
    check("rd_rsp", {23'd0, rsp_err, rsp_bit, rsp_data}, {23'd0, 1'b0, 1'b1, 8'hA5});
    tick();
    settle();
    check("rd_after_valid", 32'(rsp_valid), 32'd0);
    check("rd_hold_data", 32'(rsp_data), 32'hA5);

    // Backpressure: wrdy low for 10 ISSUE cycles
    sfr_wrdy  = 1'b0;
    req_valid = 2'b01;
    req_rd    = 2'b00;
    req_bus[0 +: BUS_W] = 29'h0055AA5;
    tick();
    settle();
    check("bp_ack", 32'(req_ack), 32'b01);
    check("bp_put0", 32'(sfr_put), 32'd0);
    req_valid = 2'b00;
    for (int i = 1; i < 10; i++) begin
      tick();
      settle();
      check("bp_stall", {29'd0, busy, sfr_put, |req_ack}, 32'b100);
    end
    tick();
    sfr_wrdy = 1'b1;
    settle();
    check("bp_put", 32'(sfr_put), 32'd1);
    check("bp_ack_once", 32'(req_ack), 32'd0);
    check("bp_bus", 32'(sfr_bus), 32'h0055AA5);
    tick();
    settle();
    check("bp_done", 32'(busy), 32'd0);

    // Timeout after 64 WAIT cycles, then late response drained
    req_valid = 2'b01;
    req_rd    = 2'b01;
    tick();
    settle();
    check("to_put", {30'd0, sfr_put, req_ack[0]}, 32'b11);
    req_valid = 2'b00;
    for (int i = 0; i < 64; i++) begin
      tick();
      settle();
      check("to_wait", {30'd0, busy, |rsp_valid}, 32'b10);
    end
    tick();
    settle();
    check("to_rsp_valid", 32'(rsp_valid), 32'b01);
    check("to_rsp", {23'd0, rsp_err, rsp_bit, rsp_data}, {23'd0, 1'b1, 1'b0, 8'h00});
    tick();
    sfr_rrdy = 1'b1;
    data_in  = 8'h5A;
    settle();
    check("drain_get", 32'(sfr_get), 32'd1);
    check("drain_busy", 32'(busy), 32'd0);
    tick();
    sfr_rrdy = 1'b0;
    settle();
    check("drain_no_rsp", 32'(rsp_valid), 32'd0);
    check("drain_err_held", 32'(rsp_err), 32'd1);

    // Drain beats a pending grant in the same cycle
    req_valid = 2'b01;
    req_rd    = 2'b00;
    sfr_rrdy  = 1'b1;
    settle();
    check("prec_get", 32'(sfr_get), 32'd1);
    tick();
    sfr_rrdy = 1'b0;
    settle();
    check("prec_no_grant", {30'd0, busy, |req_ack}, 32'd0);
    tick();
    settle();
    check("prec_ack", 32'(req_ack), 32'b01);
    req_valid = 2'b00;
    tick();

    // Asynchronous reset in the middle of WAIT
    req_valid = 2'b10;
    req_rd    = 2'b10;
    req_bus[BUS_W +: BUS_W] = 29'h1F0F0F0;
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    settle();
    exp_bus = 29'h1F0F0F0;
    check("mid_wait_bus", 32'(sfr_bus), 32'(exp_bus));
    check("mid_wait_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_outs", {sfr_put, sfr_get, busy, req_ack, rsp_valid}, 32'd0);
    check("arst_bus", 32'(sfr_bus), 32'd0);
    check("arst_rsp", {23'd0, rsp_err, rsp_bit, rsp_data}, 32'd0);
    tick();
    rst       = 1'b0;
    req_valid = 2'b11;
    req_rd    = 2'b00;
    tick();
    settle();
    check("post_rst_gnt0", 32'(req_ack), 32'b01);
    req_valid = 2'b00;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lp805x_sfr_arbiter.md
Name: lp805x_sfr_arbiter

Overview:
- Round-robin arbiter that shares one MMIO SFR peripheral port (the new timer's sfr_bus/sfr_put/sfr_get interface) between NREQ requesters, e.g. CPU SFR unit and a DMA/event sequencer.
- Serialises transactions: one write or one read in flight at a time.
- Routes read data back to the issuing requester.
- Read timeout prevents lockup; stale late responses are drained.

Parameters:
- NREQ, 2: number of requesters (2..8).
- BUS_W, 29: width of the encoded SFR transaction bus.
- TIMEOUT, 64: cycles to wait for a read response before erroring (2..2^TO_W-1).
- TO_W, 7: timeout counter width.

Ports:
- clk  in  1  arbiter clock (same domain as requesters and the CPU side of the peripheral sync FIFOs)
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester transaction request; held until req_ack
- req_rd  in  NREQ  1 = read (byte or bit), 0 = write
- req_bus  in  NREQ*BUS_W  per-requester encoded transaction; slice i = [i*BUS_W +: BUS_W]
- req_ack  out  NREQ  one-cycle pulse: request accepted and issued
- rsp_valid  out  NREQ  one-cycle pulse: read response for requester i
- rsp_data  out  8  read byte, valid with rsp_valid
- rsp_bit  out  1  read bit, valid with rsp_valid
- rsp_err  out  1  1 = read timed out; data forced 0; valid with rsp_valid
- sfr_bus  out  BUS_W  transaction to peripheral
- sfr_put  out  1  write strobe into peripheral sync FIFO
- sfr_wrdy  in  1  peripheral FIFO can accept
- sfr_get  out  1  pops peripheral response
- sfr_rrdy  in  1  peripheral response available
- data_in  in  8  peripheral response byte
- bit_in  in  1  peripheral response bit
- busy  out  1  state != IDLE

Behaviour:
- Reset values:
  - Outputs: all outputs 0, including sfr_bus.
  - State: state = IDLE, rr_ptr = NREQ-1 (requester 0 has first priority), timeout counter 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid, pick the first set bit searching from rr_ptr+1 upward, mod NREQ.
  - Latch req_bus slice, req_rd and grant index g; set rr_ptr <= g; next = ISSUE.
  - If no request and sfr_rrdy=1 (stale response): sfr_get=1 for that cycle and discard the data (drain). The drain takes precedence over a new grant in the same cycle.
- ISSUE:
  - req_ack[g]=1 for exactly the first ISSUE cycle.
  - sfr_bus drives the latched value for the whole ISSUE/WAIT duration.
  - sfr_put = sfr_wrdy (combinational); remain in ISSUE while sfr_wrdy=0.
  - On the put cycle: write -> IDLE; read -> WAIT with counter cleared.
- WAIT:
  - If sfr_rrdy=1: sfr_get=1 that cycle, capture data_in/bit_in, rsp_err <= 0, next = RESP.
  - Else increment counter. When counter == TIMEOUT-1: capture data 0/bit 0, rsp_err <= 1, next = RESP.
  - A response arriving after a timeout is drained in IDLE.
- RESP:
  - rsp_valid[g]=1 for one cycle; rsp_data/rsp_bit/rsp_err hold until the next RESP.
  - Next = IDLE.
- Latency:
  - Write: grant to put = 1 cycle when sfr_wrdy=1. Back-to-back writes issue every 2 cycles.
  - Read: put to rsp_valid = response latency + 1.
- Requester rules:
  - A requester dropping req_valid before ack is a protocol violation; the latched copy is still issued.
  - req_valid for a requester already granted is ignored until its transaction leaves ISSUE/WAIT/RESP.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,NREQ-1; no requester waits more than NREQ-1 transactions.
- Async reset mid-transaction returns to IDLE immediately with no ack/rsp pulse. The peripheral FIFO is reset by the same rst.

Test Plan:
- Single write, NREQ=2: req_valid=01, req_rd=0, sfr_wrdy=1 -> req_ack=01 one cycle later; sfr_put one cycle with sfr_bus=req_bus[28:0]; busy low on the following cycle.
- Round robin: req_valid=11 held, all writes -> grant order 0,1,0,1; req_ack alternates 01,10,01,10 at 2-cycle spacing.
- Read: requester 1 reads; peripheral raises sfr_rrdy 5 cycles after put with data_in=8'hA5, bit_in=1 -> sfr_get one cycle, then rsp_valid=10, rsp_data=A5, rsp_bit=1, rsp_err=0.
- Backpressure: sfr_wrdy=0 for 10 cycles -> stays in ISSUE, sfr_put=0; ack pulses once; put fires the cycle sfr_wrdy rises.
- Timeout and drain, TIMEOUT=64: read with no sfr_rrdy -> rsp_valid after 64 WAIT cycles with rsp_err=1, rsp_data=0. A late sfr_rrdy in IDLE with no request -> sfr_get pulse, no rsp_valid.
- Reset mid-WAIT: assert rst -> all outputs 0 asynchronously. After release, req_valid=11 -> requester 0 granted first.
